// File: rtl/sram_arbiter.sv
// Three-way arbiter for the shared external SRAM port: init, video and CPU
// take turns through fixed-length SETUP/STROBE accesses on clk28.
module sram_arbiter #(
   parameter int unsigned ADDR_W        = 19,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned CPU_MAX_SKIP  = 2
) (
   input  logic              clk28,
   input  logic              rst_n,
   input  logic              init_req,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [7:0]        init_wdata,
   output logic              init_ack,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_valid,
   output logic              cpu_wait,
   output logic [7:0]        rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dout,
   output logic              sram_doe,
   input  logic [7:0]        sram_din,
   output logic              n_vrd,
   output logic              n_vwr
);

   localparam logic [1:0] LP_LAST_PHASE = 2'(STROBE_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_VID, OWN_CPU} owner_t;

   state_t              r_state;
   logic [1:0]          r_phase;
   owner_t              r_owner;
   logic                r_we;
   logic [1:0]          r_skipCnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_wdata;
   logic                r_doe;
   logic                r_nVrd;
   logic                r_nVwr;
   logic [7:0]          r_rdata;
   logic                r_initAck;
   logic                r_vidAck;
   logic                r_cpuAck;
   logic                r_vidValid;
   logic                r_cpuValid;
   logic                r_cpuWait;

   owner_t              w_grant;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [7:0]          w_wdata;
   logic                w_promote;
   logic                w_cpuGrant;
   logic                w_cpuInFlight;

   // A CPU that has lost CPU_MAX_SKIP arbitrations in a row jumps ahead of video.
   assign w_promote     = cpu_req && (32'(r_skipCnt) >= CPU_MAX_SKIP);
   assign w_cpuGrant    = (r_state == ST_IDLE) && (w_grant == OWN_CPU);
   assign w_cpuInFlight = (r_state != ST_IDLE) && (r_owner == OWN_CPU);

   always_comb begin
      w_grant = OWN_NONE;
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      if (init_req) begin
         w_grant = OWN_INIT;
         w_we    = 1'b1;
         w_addr  = init_addr;
         w_wdata = init_wdata;
      end else if (w_promote) begin
         w_grant = OWN_CPU;
         w_we    = cpu_we;
         w_addr  = cpu_addr;
         w_wdata = cpu_wdata;
      end else if (vid_req) begin
         w_grant = OWN_VID;
         w_addr  = vid_addr;
      end else if (cpu_req) begin
         w_grant = OWN_CPU;
         w_we    = cpu_we;
         w_addr  = cpu_addr;
         w_wdata = cpu_wdata;
      end
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_phase    <= 2'd0;
         r_owner    <= OWN_NONE;
         r_we       <= 1'b0;
         r_skipCnt  <= 2'd0;
         r_addr     <= '0;
         r_wdata    <= 8'd0;
         r_doe      <= 1'b0;
         r_nVrd     <= 1'b1;
         r_nVwr     <= 1'b1;
         r_rdata    <= 8'd0;
         r_initAck  <= 1'b0;
         r_vidAck   <= 1'b0;
         r_cpuAck   <= 1'b0;
         r_vidValid <= 1'b0;
         r_cpuValid <= 1'b0;
         r_cpuWait  <= 1'b0;
      end else begin
         r_initAck  <= 1'b0;
         r_vidAck   <= 1'b0;
         r_cpuAck   <= 1'b0;
         r_vidValid <= 1'b0;
         r_cpuValid <= 1'b0;
         r_cpuWait  <= cpu_req && !w_cpuGrant && !w_cpuInFlight;
         case (r_state)
            ST_IDLE: begin
               if (w_grant != OWN_NONE) begin
                  r_state   <= ST_SETUP;
                  r_owner   <= w_grant;
                  r_we      <= w_we;
                  r_addr    <= w_addr;
                  r_wdata   <= w_wdata;
                  r_doe     <= w_we;
                  r_nVrd    <= w_we;
                  r_initAck <= (w_grant == OWN_INIT);
                  r_vidAck  <= (w_grant == OWN_VID);
                  r_cpuAck  <= (w_grant == OWN_CPU);
               end
               if (!cpu_req || w_grant == OWN_CPU) begin
                  r_skipCnt <= 2'd0;
               end else if (w_grant != OWN_NONE && r_skipCnt != 2'd3) begin
                  r_skipCnt <= r_skipCnt + 2'd1;
               end
            end
            ST_SETUP: begin
               r_state <= ST_STROBE;
               r_phase <= 2'd0;
               r_nVwr  <= !r_we;
            end
            // The edge that ends the last STROBE cycle captures read data and releases the bus.
            ST_STROBE: begin
               if (r_phase == LP_LAST_PHASE) begin
                  r_state    <= ST_IDLE;
                  r_nVrd     <= 1'b1;
                  r_nVwr     <= 1'b1;
                  r_doe      <= 1'b0;
                  if (!r_we) begin
                     r_rdata <= sram_din;
                  end
                  r_vidValid <= (r_owner == OWN_VID);
                  r_cpuValid <= (r_owner == OWN_CPU);
               end else begin
                  r_phase <= r_phase + 2'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign init_ack  = r_initAck;
   assign vid_ack   = r_vidAck;
   assign vid_valid = r_vidValid;
   assign cpu_ack   = r_cpuAck;
   assign cpu_valid = r_cpuValid;
   assign cpu_wait  = r_cpuWait;
   assign rdata     = r_rdata;
   assign sram_addr = r_addr;
   assign sram_dout = r_wdata;
   assign sram_doe  = r_doe;
   assign n_vrd     = r_nVrd;
   assign n_vwr     = r_nVwr;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a transaction-timeline model predicts every
// output each cycle from the grant cycle of the access in flight.
module tb_sram_arbiter;

   localparam int ADDR_W  = 19;
   localparam int STROBE  = 2;
   localparam int MAXSKIP = 2;
   localparam int OWN_NONE = 0;
   localparam int OWN_INIT = 1;
   localparam int OWN_VID  = 2;
   localparam int OWN_CPU  = 3;

   typedef struct {
      logic              initAck, vidAck, cpuAck, vidValid, cpuValid, cpuWait;
      logic              nVrd, nVwr, doe, chkAddr, chkDout;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        dout;
      logic [7:0]        rdata;
   } exp_t;

   logic              clk28 = 1'b0;
   logic              rst_n;
   logic              init_req, vid_req, cpu_req, cpu_we;
   logic [ADDR_W-1:0] init_addr, vid_addr, cpu_addr;
   logic [7:0]        init_wdata, cpu_wdata;
   logic              init_ack, vid_ack, vid_valid, cpu_ack, cpu_valid, cpu_wait;
   logic [7:0]        rdata, sram_dout, sram_din;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_doe, n_vrd, n_vwr;

   int   checkCount = 0;
   int   errCount   = 0;
   int   cycle      = 0;

   // Behavioural SRAM: data is a fixed hash of the address unless overridden.
   logic       dinMode  = 1'b0;
   logic [7:0] dinConst = 8'h00;

   // Stimulus controls
   int   probInit = 0, probVid = 0, probCpu = 0, randResetProb = 0, forceReset = 0;
   bit   randWe = 0, armVidReset = 0, vidResetHit = 0;
   bit   cpuShot = 0, vidShot = 0;
   logic              shotWe;
   logic [ADDR_W-1:0] shotAddr;
   logic [7:0]        shotData;

   // Reference model state
   int                gCycle = -100;
   int                mOwner = OWN_NONE;
   int                mSkip  = 0;
   logic              mWe    = 1'b0;
   logic [ADDR_W-1:0] mAddr  = '0;
   logic [7:0]        mData  = 8'd0;
   logic [7:0]        mRdata = 8'd0;
   exp_t              expv;

   always #5 clk28 = ~clk28;

   function automatic logic [7:0] dinHash(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h3C;
   endfunction

   assign sram_din = dinMode ? dinConst : dinHash(sram_addr);

   sram_arbiter #(.ADDR_W(ADDR_W), .STROBE_CYCLES(STROBE), .CPU_MAX_SKIP(MAXSKIP)) dut (
      .clk28(clk28), .rst_n(rst_n),
      .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata), .init_ack(init_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_wait(cpu_wait),
      .rdata(rdata), .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
      .sram_din(sram_din), .n_vrd(n_vrd), .n_vwr(n_vwr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s cycle %0d observed=%0h expected=%0h", tag, cycle, observed, expected);
      end
   endtask

   function automatic exp_t resetExp();
      exp_t e;
      e.initAck = 0; e.vidAck = 0; e.cpuAck = 0; e.vidValid = 0; e.cpuValid = 0;
      e.cpuWait = 0; e.nVrd = 1; e.nVwr = 1; e.doe = 0; e.chkAddr = 1; e.chkDout = 1;
      e.addr = '0; e.dout = 8'd0; e.rdata = 8'd0;
      return e;
   endfunction

   task automatic compareAll();
      checkOutput("init_ack", 32'(init_ack), 32'(expv.initAck));
      checkOutput("vid_ack", 32'(vid_ack), 32'(expv.vidAck));
      checkOutput("cpu_ack", 32'(cpu_ack), 32'(expv.cpuAck));
      checkOutput("vid_valid", 32'(vid_valid), 32'(expv.vidValid));
      checkOutput("cpu_valid", 32'(cpu_valid), 32'(expv.cpuValid));
      checkOutput("cpu_wait", 32'(cpu_wait), 32'(expv.cpuWait));
      checkOutput("n_vrd", 32'(n_vrd), 32'(expv.nVrd));
      checkOutput("n_vwr", 32'(n_vwr), 32'(expv.nVwr));
      checkOutput("sram_doe", 32'(sram_doe), 32'(expv.doe));
      checkOutput("rdata", 32'(rdata), 32'(expv.rdata));
      if (expv.chkAddr) checkOutput("sram_addr", 32'(sram_addr), 32'(expv.addr));
      if (expv.chkDout) checkOutput("sram_dout", 32'(sram_dout), 32'(expv.dout));
   endtask

   // Drive this cycle's inputs; requesters release a request once its ack is due.
   task automatic applyStimulus();
      rst_n = 1'b1;
      if (forceReset > 0) begin
         rst_n = 1'b0;
         forceReset--;
      end else if (armVidReset && mOwner == OWN_VID && (cycle - gCycle) == 3) begin
         rst_n       = 1'b0;
         armVidReset = 0;
         vidResetHit = 1;
      end else if (randResetProb > 0 && $urandom_range(999) < randResetProb) begin
         rst_n = 1'b0;
      end
      if (expv.initAck) init_req = 1'b0;
      if (expv.vidAck)  vid_req  = 1'b0;
      if (expv.cpuAck)  cpu_req  = 1'b0;
      if (!init_req && $urandom_range(99) < probInit) begin
         init_req   = 1'b1;
         init_addr  = ADDR_W'($urandom);
         init_wdata = 8'($urandom);
      end
      if (!vid_req && (vidShot || $urandom_range(99) < probVid)) begin
         vid_req  = 1'b1;
         vid_addr = ADDR_W'($urandom);
         vidShot  = 0;
      end
      if (!cpu_req && cpuShot) begin
         cpu_req   = 1'b1;
         cpu_we    = shotWe;
         cpu_addr  = shotAddr;
         cpu_wdata = shotData;
         cpuShot   = 0;
      end else if (!cpu_req && $urandom_range(99) < probCpu) begin
         cpu_req   = 1'b1;
         cpu_we    = randWe ? 1'($urandom_range(1)) : 1'b0;
         cpu_addr  = ADDR_W'($urandom);
         cpu_wdata = 8'($urandom);
      end
   endtask

   // Predict next cycle's outputs from the offset relative to the last grant.
   task automatic modelStep();
      bit idle, inFlightCpu;
      int win, off;
      if (!rst_n) begin
         gCycle = -100; mOwner = OWN_NONE; mSkip = 0; mRdata = 8'd0;
         expv = resetExp();
         return;
      end
      idle        = (cycle >= gCycle + 2 + STROBE);
      inFlightCpu = !idle && (mOwner == OWN_CPU);
      win         = OWN_NONE;
      if (idle) begin
         if (init_req)                         win = OWN_INIT;
         else if (cpu_req && mSkip >= MAXSKIP) win = OWN_CPU;
         else if (vid_req)                     win = OWN_VID;
         else if (cpu_req)                     win = OWN_CPU;
         if (win != OWN_NONE) begin
            gCycle = cycle;
            mOwner = win;
            case (win)
               OWN_INIT: begin mWe = 1'b1; mAddr = init_addr; mData = init_wdata; end
               OWN_VID:  begin mWe = 1'b0; mAddr = vid_addr;  mData = 8'd0; end
               default:  begin mWe = cpu_we; mAddr = cpu_addr; mData = cpu_wdata; end
            endcase
         end
         if (!cpu_req || win == OWN_CPU) mSkip = 0;
         else if (win != OWN_NONE && mSkip < 3) mSkip++;
      end
      off = cycle + 1 - gCycle;
      expv.cpuWait  = cpu_req && (win != OWN_CPU) && !inFlightCpu;
      expv.initAck  = (off == 1) && (mOwner == OWN_INIT);
      expv.vidAck   = (off == 1) && (mOwner == OWN_VID);
      expv.cpuAck   = (off == 1) && (mOwner == OWN_CPU);
      expv.nVrd     = !((off >= 1) && (off <= 1 + STROBE) && !mWe);
      expv.nVwr     = !((off >= 2) && (off <= 1 + STROBE) && mWe);
      expv.doe      = (off >= 1) && (off <= 1 + STROBE) && mWe;
      expv.chkAddr  = (off >= 1) && (off <= 1 + STROBE);
      expv.chkDout  = expv.doe;
      expv.addr     = mAddr;
      expv.dout     = mData;
      expv.vidValid = (off == 2 + STROBE) && (mOwner == OWN_VID);
      expv.cpuValid = (off == 2 + STROBE) && (mOwner == OWN_CPU);
      if (off == 2 + STROBE && !mWe) mRdata = dinMode ? dinConst : dinHash(mAddr);
      expv.rdata    = mRdata;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk28);
         #1;
         cycle++;
         compareAll();
         applyStimulus();
         modelStep();
      end
   endtask

   initial begin
      // Reset held for three edges with every requester asserted.
      rst_n      = 1'b0;
      init_req   = 1'b1; init_addr = ADDR_W'($urandom); init_wdata = 8'($urandom);
      vid_req    = 1'b1; vid_addr  = ADDR_W'($urandom);
      cpu_req    = 1'b1; cpu_we    = 1'b0; cpu_addr = ADDR_W'($urandom); cpu_wdata = 8'($urandom);
      shotWe     = 1'b0; shotAddr  = '0; shotData = 8'd0;
      expv       = resetExp();
      forceReset = 2;
      runCycles(24);

      dinMode = 1'b1; dinConst = 8'h5A;
      shotWe = 1'b0; shotAddr = ADDR_W'(32'h1ABCD); shotData = 8'h00; cpuShot = 1;
      runCycles(10);
      dinMode = 1'b0;

      shotWe = 1'b1; shotAddr = ADDR_W'(32'h00010); shotData = 8'h3C; cpuShot = 1;
      runCycles(10);

      probVid = 100; probCpu = 100;
      runCycles(40);
      probVid = 0; probCpu = 0;
      runCycles(12);

      vidShot = 1; armVidReset = 1;
      runCycles(12);
      checkOutput("vid_reset_hit", 32'(vidResetHit), 32'd1);

      probInit = 5; probVid = 40; probCpu = 40; randWe = 1; randResetProb = 3;
      runCycles(3000);
      probInit = 0; probVid = 0; probCpu = 0; randResetProb = 0;
      runCycles(12);

      $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
      $finish;
   end

endmodule
